tirage_de: RTL

TIRAGE_DE -- requirements
Module: tirage_de

---
 rtl/tirage_de_pkg.sv | 25 ++
 rtl/lfsr16.sv | 24 ++
 rtl/tirage_de.sv | 81 ++++++++
 3 files changed

// File: rtl/tirage_de_pkg.sv
// Shared constants for the dice roller: state encoding, LFSR seed/taps, face width.
package tirage_de_pkg;

   localparam int FACE_W = 7;
   localparam int LFSR_W = 16;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Tap positions 16,14,13,11 expressed as zero-based bit indices
   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

   localparam logic [1:0] ST_REPOS   = 2'd0;
   localparam logic [1:0] ST_REDUIRE = 2'd1;
   localparam logic [1:0] ST_FIN     = 2'd2;

   // Number of faces between the bounds; inverted bounds collapse to one face.
   function automatic logic [7:0] span_of(input logic [FACE_W-1:0] lo,
                                          input logic [FACE_W-1:0] hi);
      if (hi < lo) return 8'd1;
      return {1'b0, hi} - {1'b0, lo} + 8'd1;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifts every clock.
module lfsr16
   import tirage_de_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] lfsr
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[LFSR_W-2:0],
                lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/tirage_de.sv
// Dice roller: samples the LFSR on request and reduces it into [dMin,dMax]
// by repeated subtraction, one step per cycle.
module tirage_de
   import tirage_de_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              lancer,
   input  logic [FACE_W-1:0] dMin,
   input  logic [FACE_W-1:0] dMax,
   output logic [FACE_W-1:0] resultat,
   output logic              pret,
   output logic              occupe
);

   logic [LFSR_W-1:0] lfsr;
   logic [1:0]        state_q, state_d;
   logic [7:0]        r_q, r_d;
   logic [7:0]        span_q, span_d;
   logic [FACE_W-1:0] min_l_q, min_l_d;
   logic [FACE_W-1:0] res_q, res_d;
   logic [7:0]        sum;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign sum = r_q + {1'b0, min_l_q};

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      span_d  = span_q;
      min_l_d = min_l_q;
      res_d   = res_q;
      case (state_q)
         ST_REPOS: begin
            if (lancer) begin
               // Low seven LFSR bits as seen before this edge's shift
               r_d     = 8'(lfsr & 16'h007F);
               min_l_d = dMin;
               span_d  = span_of(dMin, dMax);
               state_d = ST_REDUIRE;
            end
         end
         ST_REDUIRE: begin
            if (r_q >= span_q) begin
               r_d = r_q - span_q;
            end else begin
               res_d   = sum[FACE_W-1:0];
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_REPOS;
         default: state_d = ST_REPOS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_REPOS;
         r_q     <= '0;
         span_q  <= '0;
         min_l_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         span_q  <= span_d;
         min_l_q <= min_l_d;
         res_q   <= res_d;
      end
   end

   assign resultat = res_q;
   assign pret     = (state_q == ST_FIN);
   assign occupe   = (state_q != ST_REPOS);

endmodule
